// File: rtl/wbrd2axilm.sv
// wbrd2axilm: read-only bridge from a pipelined Wishbone slave port to an
// AXI-lite read master. Every accepted WB read strobe becomes one AR beat.
// R beats come back strictly in order, as o_wb_ack (OKAY/EXOKAY) or as
// o_wb_err (SLVERR/DECERR). When a cycle is abandoned, or ends in an error
// while reads are still outstanding, the bridge enters FLUSH. In FLUSH it
// quietly drains the remaining R beats before it serves a new cycle.
module wbrd2axilm #(
   parameter int C_AXI_ADDR_WIDTH = 28,
   parameter int LGFIFO           = 3
) (
   input  logic                          i_clk,
   input  logic                          w_reset,
   // Wishbone pipelined slave
   input  logic                          i_wb_cyc,
   input  logic                          i_wb_stb,
   input  logic                          i_wb_we,
   input  logic [C_AXI_ADDR_WIDTH-3:0]   i_wb_addr,
   output logic                          o_wb_stall,
   output logic                          o_wb_ack,
   output logic [31:0]                   o_wb_data,
   output logic                          o_wb_err,
   // AXI-lite read master
   output logic                          o_axi_arvalid,
   input  logic                          i_axi_arready,
   output logic [C_AXI_ADDR_WIDTH-1:0]   o_axi_araddr,
   output logic [2:0]                    o_axi_arprot,
   input  logic                          i_axi_rvalid,
   output logic                          o_axi_rready,
   input  logic [31:0]                   i_axi_rdata,
   input  logic [1:0]                    i_axi_rresp
);

   // The outstanding-read counter needs one extra bit so that it can hold 2**LGFIFO.
   localparam logic [LGFIFO:0] NPEND_MAX  = {1'b1, {LGFIFO{1'b0}}};
   localparam logic [LGFIFO:0] NPEND_ONE  = {{LGFIFO{1'b0}}, 1'b1};
   localparam logic [LGFIFO:0] NPEND_ZERO = '0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic [LGFIFO:0]               npend_q, npend_d;
   logic                          arvalid_q, arvalid_d;
   logic [C_AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic                          ack_q, ack_d;
   logic                          err_q, err_d;
   logic [31:0]                   data_q, data_d;

   logic                          stall;
   logic                          rd_accept;
   logic                          wr_accept;
   logic                          r_beat;
   logic                          r_deliver;

   // Only the error bit of rresp matters: OKAY and EXOKAY both map to an ack.
   logic unused_rresp;
   assign unused_rresp = &{1'b0, i_axi_rresp[0]};

   // Stall and accept decode. A write strobe has to wait until every read has
   // completed, so that its error pulse stays in order with the read responses.
   always_comb begin
      stall     = 1'b0;
      rd_accept = 1'b0;
      wr_accept = 1'b0;
      r_beat    = 1'b0;
      r_deliver = 1'b0;

      if (arvalid_q && !i_axi_arready)
         stall = 1'b1;
      if (npend_q == NPEND_MAX)
         stall = 1'b1;
      if (state_q != ST_ACTIVE)
         stall = 1'b1;
      if (i_wb_we && (npend_q != NPEND_ZERO))
         stall = 1'b1;

      rd_accept = i_wb_cyc && i_wb_stb && !i_wb_we && !stall;
      wr_accept = i_wb_cyc && i_wb_stb &&  i_wb_we && !stall;

      // rready is tied high, so every rvalid is a completed beat. A beat that
      // arrives with nothing outstanding is a fabric fault, and the counter
      // ignores it rather than wrapping.
      r_beat    = i_axi_rvalid && (npend_q != NPEND_ZERO);
      r_deliver = i_axi_rvalid && (state_q == ST_ACTIVE) && i_wb_cyc;
   end

   // Next-state logic for the cycle FSM and the outstanding-read counter.
   always_comb begin
      state_d = state_q;
      npend_d = npend_q;

      unique case ({rd_accept, r_beat})
         2'b10:   npend_d = npend_q + NPEND_ONE;
         2'b01:   npend_d = npend_q - NPEND_ONE;
         default: npend_d = npend_q;
      endcase

      unique case (state_q)
         ST_IDLE: begin
            if (i_wb_cyc)
               state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (!i_wb_cyc) begin
               if (npend_q == NPEND_ZERO)
                  state_d = ST_IDLE;
               else
                  state_d = ST_FLUSH;
            end else if (r_deliver && i_axi_rresp[1] && (npend_d != NPEND_ZERO)) begin
               // Only the first error of a burst is reported. Later beats of
               // that cycle carry no meaning for the master.
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if ((npend_q == NPEND_ZERO) && !arvalid_q)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next-state logic for the AR channel and the WB response datapath.
   always_comb begin
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      data_d    = data_q;

      // An AR beat holds still until it is accepted. A new accept in the
      // handshake cycle reloads the beat directly.
      if (rd_accept) begin
         arvalid_d = 1'b1;
         araddr_d  = {i_wb_addr, 2'b00};
      end else if (i_axi_arready) begin
         arvalid_d = 1'b0;
      end

      if (r_deliver) begin
         data_d = i_axi_rdata;
         ack_d  = !i_axi_rresp[1];
         err_d  =  i_axi_rresp[1];
      end

      // Writes are unsupported. They are answered with a bus error and never
      // reach AXI.
      if (wr_accept)
         err_d = 1'b1;
   end

   // State register. The AXI side shares the same synchronous reset.
   always_ff @(posedge i_clk) begin
      if (w_reset) begin
         state_q   <= ST_IDLE;
         npend_q   <= '0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         npend_q   <= npend_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         data_q    <= data_d;
      end
   end

   // Responses are masked while CYC is low, so an abandoned cycle never sees a
   // stray ack or err pulse.
   assign o_wb_stall    = stall;
   assign o_wb_ack      = ack_q && i_wb_cyc;
   assign o_wb_err      = err_q && i_wb_cyc;
   assign o_wb_data     = data_q;
   assign o_axi_arvalid = arvalid_q;
   assign o_axi_araddr  = araddr_q;
   assign o_axi_arprot  = 3'b000;
   assign o_axi_rready  = 1'b1;

endmodule
